// File: rtl/alu_serial_logic.sv
// Bit-serial 8-bit logic unit (AND/OR/XOR/NOR): one result bit per clock, LSB first.
// Optional zero/parity flag outputs are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial_logic (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [1:0] op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Y,
    output logic       busy,
`ifdef ALU_SERIAL_FLAGS_EN
    output logic       zero,
    output logic       parity,
`endif
    output logic [1:0] state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a producer holds its payload until taken.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [7:0] a_cap;
    logic [7:0] b_cap;
    logic [1:0] op_cap;
    logic [7:0] sr;
    logic       res_bit;
    logic [7:0] sr_next;
    logic       accept;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign state_dbg = state;
    assign accept    = in_valid & in_ready;

    always_comb begin
        res_bit = 1'b0;
        case (op_cap)
            OP_AND:  res_bit = a_cap[cnt] & b_cap[cnt];
            OP_OR:   res_bit = a_cap[cnt] | b_cap[cnt];
            OP_XOR:  res_bit = a_cap[cnt] ^ b_cap[cnt];
            default: res_bit = ~(a_cap[cnt] | b_cap[cnt]);
        endcase
    end

    // New bit enters at the top; after eight shifts bit 0 has reached position 0.
    assign sr_next = {res_bit, sr[7:1]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 3'd0;
            a_cap  <= 8'h00;
            b_cap  <= 8'h00;
            op_cap <= 2'b00;
            sr     <= 8'h00;
            Y      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_cap  <= A;
                        b_cap  <= B;
                        op_cap <= op;
                        cnt    <= 3'd0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        Y <= sr_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (state == SHIFT && cnt == 3'd7) begin
            zero   <= (sr_next == 8'h00);
            parity <= ^sr_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_logic.sv
// Directed bench for alu_serial_logic: reset, each op, hold, input scrambling,
// mid-operation reset and back-to-back throughput.
module tb_alu_serial_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [1:0] op_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;
    logic       busy;
    logic [1:0] state_dbg;
`ifdef ALU_SERIAL_FLAGS_EN
    logic       zero;
    logic       parity;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial_logic dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .op        (op_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (y_out),
        .busy      (busy),
`ifdef ALU_SERIAL_FLAGS_EN
        .zero      (zero),
        .parity    (parity),
`endif
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] exp_y);
`ifdef ALU_SERIAL_FLAGS_EN
        chk({tag, "_zero"}, {7'd0, zero}, {7'd0, exp_y == 8'h00});
        chk({tag, "_parity"}, {7'd0, parity}, {7'd0, ^exp_y});
`else
        if (exp_y === 8'hxx) $display("unused %s", tag);
`endif
    endtask

    // Starts in IDLE; accepts one operation and checks all 8 SHIFT cycles and the result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                          input logic [7:0] exp_y, input logic [7:0] prev_y,
                          input bit scramble, input string tag);
        a_in     = a;
        b_in     = b;
        op_in    = o;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_ov_low"}, {7'd0, out_valid}, 8'd0);
            chk({tag, "_ir_low"}, {7'd0, in_ready}, 8'd0);
            chk({tag, "_y_hold"}, y_out, prev_y);
            if (scramble) begin
                a_in     = 8'($urandom_range(0, 255));
                b_in     = 8'($urandom_range(0, 255));
                op_in    = 2'($urandom_range(0, 3));
                in_valid = 1'($urandom_range(0, 1));
            end
            tick();
        end
        in_valid = 1'b0;
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
        chk({tag, "_busy_off"}, {7'd0, busy}, 8'd0);
        chk({tag, "_y"}, y_out, exp_y);
        chk_flags(tag, exp_y);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_ov"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_rel_ir"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 8'h00;
        b_in      = 8'h00;
        op_in     = 2'b00;
        tick();
        tick();
        chk("rst_y", y_out, 8'h00);
        chk("rst_ov", {7'd0, out_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_ir", {7'd0, in_ready}, 8'd1);
        chk_flags("rst", 8'h00);

        // Reset wins over a simultaneous accept.
        in_valid = 1'b1;
        a_in     = 8'hFF;
        tick();
        chk("rst_prio_busy", {7'd0, busy}, 8'd0);
        chk("rst_prio_ir", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        run_op(8'hF0, 8'h3C, 2'b01, 8'hFC, 8'h00, 1'b0, "or_f0_3c");
        release_result("or_f0_3c");
        run_op(8'hAA, 8'h55, 2'b00, 8'h00, 8'hFC, 1'b0, "and_aa_55");
        release_result("and_aa_55");
        run_op(8'hAA, 8'h55, 2'b10, 8'hFF, 8'h00, 1'b0, "xor_aa_55");
        release_result("xor_aa_55");

        // Long hold in DONE with a new request pending.
        run_op(8'h0F, 8'h01, 2'b11, 8'hF0, 8'hFF, 1'b0, "nor_0f_01");
        in_valid = 1'b1;
        a_in     = 8'h12;
        b_in     = 8'h34;
        op_in    = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_y", y_out, 8'hF0);
            chk("hold_ov", {7'd0, out_valid}, 8'd1);
            chk("hold_ir", {7'd0, in_ready}, 8'd0);
            chk("hold_busy", {7'd0, busy}, 8'd0);
        end
        // Edge leaving DONE must not accept even though in_valid is high.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("leave_done_ir", {7'd0, in_ready}, 8'd1);
        chk("leave_done_busy", {7'd0, busy}, 8'd0);
        chk("leave_done_ov", {7'd0, out_valid}, 8'd0);
        tick();
        chk("no_accept_idle", {7'd0, in_ready}, 8'd1);

        run_op(8'h81, 8'h18, 2'b01, 8'h99, 8'hF0, 1'b1, "scramble");
        release_result("scramble");
        run_op(8'h07, 8'h00, 2'b01, 8'h07, 8'h99, 1'b0, "or_07");
        release_result("or_07");

        // Reset in the middle of an operation.
        a_in     = 8'hFF;
        b_in     = 8'h0F;
        op_in    = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", {7'd0, busy}, 8'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_ir", {7'd0, in_ready}, 8'd1);
        chk("mid_rst_ov", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_y", y_out, 8'h00);
        chk_flags("mid_rst", 8'h00);
        run_op(8'h3C, 8'h0F, 2'b10, 8'h33, 8'h00, 1'b0, "after_rst");
        release_result("after_rst");

        // Back-to-back with in_valid and out_ready held high: accepts 10 edges apart.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 8'hC3;
        b_in      = 8'h5A;
        op_in     = 2'b00;
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] exp_y;
            case (k)
                0:       exp_y = 8'h42;
                1:       exp_y = 8'hE0;
                default: exp_y = 8'h00;
            endcase
            case (k)
                0:       begin a_in = 8'hF0; b_in = 8'h10; op_in = 2'b10; end
                1:       begin a_in = 8'hFF; b_in = 8'h00; op_in = 2'b11; end
                default: begin a_in = 8'h00; b_in = 8'h00; op_in = 2'b00; end
            endcase
            for (int i = 0; i < 7; i++) tick();
            chk("b2b_ov_early", {7'd0, out_valid}, 8'd0);
            tick();
            chk("b2b_ov", {7'd0, out_valid}, 8'd1);
            chk("b2b_y", y_out, exp_y);
            tick();
            chk("b2b_idle", {7'd0, in_ready}, 8'd1);
            tick();
            chk("b2b_accept", {7'd0, busy}, 8'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_logic.md
ALU_SERIAL_LOGIC -- requirements
Module: alu_serial_logic

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have ports A and B, inputs, 8 bits each: operands, sampled only on accept.
REQ-006 SHALL have port op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NOR; sampled only on accept.
REQ-007 SHALL have port out_valid, output, 1 bit: Y holds a completed result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-009 SHALL have port Y, output, 8 bits: registered result.
REQ-010 SHALL have port busy, output, 1 bit: high while in SHIFT.

Function
REQ-011 SHALL implement states IDLE, SHIFT, DONE; state encoding is free.
REQ-012 in_ready SHALL be 1 exactly when state is IDLE; 0 in SHIFT and DONE.
REQ-013 Accept = in_valid & in_ready at a rising edge; on accept SHALL capture A, B, op, clear 3-bit bit counter, go to SHIFT.
REQ-014 In SHIFT SHALL compute one result bit per cycle, LSB first: bit[cnt] = op applied to A_cap[cnt], B_cap[cnt].
REQ-015 Result bits SHALL accumulate in an internal shift register; counter increments each SHIFT cycle.
REQ-016 On the SHIFT edge where cnt == 7, SHALL load the full 8-bit result into Y and go to DONE.
REQ-017 Latency: accept at edge T -> out_valid high after edge T+8; exactly 8 SHIFT cycles per operation.
REQ-018 In DONE, out_valid SHALL be 1 and Y stable; on out_ready at an edge SHALL go to IDLE and drop out_valid.
REQ-019 While out_ready is 0 in DONE, SHALL hold Y and out_valid indefinitely.
REQ-020 Y SHALL keep the previous result during SHIFT and IDLE; it changes only on REQ-016.
REQ-021 No accept SHALL occur on the edge leaving DONE; earliest new accept is the following edge (throughput: one op per 10 cycles minimum).
REQ-022 in_valid, A, B, op changes outside IDLE SHALL have no effect.
REQ-023 Counter SHALL not wrap into a ninth SHIFT cycle.

Reset
REQ-024 On rst at an edge SHALL enter IDLE regardless of state, discarding any operation in progress.
REQ-025 Reset values: Y = 8'h00, out_valid = 0, busy = 0, in_ready = 1 (from IDLE), counter = 0, captured operands = 0.
REQ-026 rst SHALL take priority over accept and over out_ready in the same cycle.

Configuration
REQ-027 Macro ALU_SERIAL_FLAGS_EN, when defined, SHALL add outputs zero (1 bit) and parity (1 bit).
REQ-028 With macro: zero = (Y == 0), parity = XOR of Y bits, both registered, updated with Y, reset to zero=1, parity=0.
REQ-029 Without macro: ports zero and parity SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset then A=8'hF0, B=8'h3C, op=01 -> out_valid after 8 cycles, Y=8'hFC; busy high exactly 8 cycles.
REQ-031 A=8'hAA, B=8'h55, op=00 -> Y=8'h00 (with macro zero=1, parity=0); op=10 -> Y=8'hFF (zero=0, parity=0).
REQ-032 A=8'h0F, B=8'h01, op=11 -> Y=8'hF0; hold out_ready=0 20 cycles -> Y, out_valid stable, in_ready=0, in_valid ignored.
REQ-033 Change A/B/op every cycle during SHIFT after accepting A=8'h81, B=8'h18, op=01 -> Y=8'h99 unaffected.
REQ-034 Assert rst at SHIFT cycle 4 -> next cycle IDLE, in_ready=1, out_valid=0, Y=8'h00; next op completes normally.
REQ-035 Back-to-back: in_valid held high, out_ready held high -> accepts spaced exactly 10 cycles, each Y correct.
